// File: rtl/button_press_gen.sv
// Emulated active-low mechanical button: emits a burst of bounced presses on request.
// Drive end of the button loopback; every output comes straight from a flop.
module button_press_gen #(
  parameter int CNT_W         = 4,
  parameter int BOUNCE_EDGES  = 4,
  parameter int BOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1000,
  parameter int GAP_CYCLES    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] press_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] presses_sent,
  output logic             btn_n
);

  localparam int MAX_AB  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int SEG_W   = (BOUNCE_EDGES > 1) ? $clog2(BOUNCE_EDGES) : 1;

  localparam logic [TMR_W-1:0] BOUNCE_LOAD = TMR_W'(BOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD    = TMR_W'(GAP_CYCLES - 1);
  localparam logic [SEG_W-1:0] SEG_LAST    = SEG_W'((BOUNCE_EDGES > 0) ? BOUNCE_EDGES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    REL_BOUNCE,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] presses_d;
  logic             launch_q, launch_d;
  logic             zero_q, zero_d;
  logic             btn_n_d, busy_d, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      seg_q        <= '0;
      target_q     <= '0;
      launch_q     <= 1'b0;
      zero_q       <= 1'b0;
      btn_n        <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      presses_sent <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      seg_q        <= seg_d;
      target_q     <= target_d;
      launch_q     <= launch_d;
      zero_q       <= zero_d;
      btn_n        <= btn_n_d;
      busy         <= busy_d;
      done         <= done_d;
      presses_sent <= presses_d;
    end
  end

  // An accepted start spends one cycle in IDLE (launch/zero pending) before acting,
  // so busy and the first low level appear on the edge after the request is sampled.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    seg_d     = seg_q;
    target_d  = target_q;
    launch_d  = launch_q;
    zero_d    = zero_q;
    btn_n_d   = btn_n;
    busy_d    = busy;
    done_d    = 1'b0;
    presses_d = presses_sent;

    case (state_q)
      IDLE: begin
        if (abort) begin
          launch_d = 1'b0;
          zero_d   = 1'b0;
        end else if (launch_q) begin
          launch_d = 1'b0;
          busy_d   = 1'b1;
          btn_n_d  = 1'b0;
          seg_d    = '0;
          if (BOUNCE_EDGES != 0) begin
            state_d = PRESS_BOUNCE;
            timer_d = BOUNCE_LOAD;
          end else begin
            state_d = HOLD;
            timer_d = HOLD_LOAD;
          end
        end else if (zero_q) begin
          zero_d = 1'b0;
          done_d = 1'b1;
        end else if (start) begin
          if (press_count != '0) begin
            target_d  = press_count;
            presses_d = '0;
            launch_d  = 1'b1;
          end else begin
            zero_d = 1'b1;
          end
        end
      end

      PRESS_BOUNCE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (seg_q == SEG_LAST) begin
          state_d = HOLD;
          timer_d = HOLD_LOAD;
          btn_n_d = 1'b0;
        end else begin
          seg_d   = seg_q + 1'b1;
          timer_d = BOUNCE_LOAD;
          btn_n_d = ~btn_n;
        end
      end

      HOLD: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (BOUNCE_EDGES != 0) begin
          state_d = REL_BOUNCE;
          timer_d = BOUNCE_LOAD;
          seg_d   = '0;
          btn_n_d = 1'b1;
        end else begin
          state_d   = GAP;
          timer_d   = GAP_LOAD;
          btn_n_d   = 1'b1;
          presses_d = presses_sent + 1'b1;
        end
      end

      REL_BOUNCE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (seg_q == SEG_LAST) begin
          state_d   = GAP;
          timer_d   = GAP_LOAD;
          btn_n_d   = 1'b1;
          presses_d = presses_sent + 1'b1;
        end else begin
          seg_d   = seg_q + 1'b1;
          timer_d = BOUNCE_LOAD;
          btn_n_d = ~btn_n;
        end
      end

      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (presses_sent != target_q) begin
          btn_n_d = 1'b0;
          seg_d   = '0;
          if (BOUNCE_EDGES != 0) begin
            state_d = PRESS_BOUNCE;
            timer_d = BOUNCE_LOAD;
          end else begin
            state_d = HOLD;
            timer_d = HOLD_LOAD;
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        btn_n_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides whatever the active state decided, including a pending count increment.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      btn_n_d   = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      presses_d = presses_sent;
    end
  end

endmodule

// File: tb/tb_button_press_gen.sv
// Bench for button_press_gen: directed and random bursts checked against a
// per-cycle waveform model built from the press timing rules.
module tb_button_press_gen;

  localparam int CNT_W = 4;
  localparam int BE    = 2;
  localparam int BC    = 3;
  localparam int HC    = 5;
  localparam int GC    = 4;
  localparam int P     = 2 * BE * BC + HC + GC;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] press_count;
  logic             busy;
  logic             done;
  logic             btn_n;
  logic [CNT_W-1:0] presses_sent;

  int assertions = 0;
  int failures   = 0;

  bit wave_q[$];
  int sent_q[$];

  int   lb_run   = 0;
  int   lb_count = 0;
  logic lb_clear;

  button_press_gen #(
    .CNT_W(CNT_W),
    .BOUNCE_EDGES(BE),
    .BOUNCE_CYCLES(BC),
    .HOLD_CYCLES(HC),
    .GAP_CYCLES(GC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .press_count(press_count),
    .abort(abort),
    .busy(busy),
    .done(done),
    .presses_sent(presses_sent),
    .btn_n(btn_n)
  );

  always #5 clk = ~clk;

  // Crude debounced receiver: one count per low run longer than any bounce segment.
  always @(posedge clk) begin
    if (lb_clear) begin
      lb_run   <= 0;
      lb_count <= 0;
    end else if (!btn_n) begin
      lb_run <= lb_run + 1;
      if (lb_run == BC) lb_count <= lb_count + 1;
    end else begin
      lb_run <= 0;
    end
  end

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] c, input logic a);
    start       = s;
    press_count = c;
    abort       = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected btn_n level and presses_sent for every cycle of an n-press burst.
  task automatic buildWave(input int n);
    wave_q.delete();
    sent_q.delete();
    for (int p = 0; p < n; p++) begin
      for (int s = 0; s < BE; s++)
        for (int c = 0; c < BC; c++) begin wave_q.push_back(s % 2 != 0); sent_q.push_back(p); end
      for (int c = 0; c < HC; c++) begin wave_q.push_back(1'b0); sent_q.push_back(p); end
      for (int s = 0; s < BE; s++)
        for (int c = 0; c < BC; c++) begin wave_q.push_back(s % 2 == 0); sent_q.push_back(p); end
      for (int c = 0; c < GC; c++) begin wave_q.push_back(1'b1); sent_q.push_back(p + 1); end
    end
  endtask

  task automatic runBurst(input int n, input int abort_idx, input bit rand_start);
    buildWave(n);
    nextCycle();
    applyStimulus(1'b1, CNT_W'(n), 1'b0);
    nextCycle();
    checkOutput("accept_busy", busy, 0);
    checkOutput("accept_btn", btn_n, 1);
    checkOutput("accept_cleared", presses_sent, 0);
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < wave_q.size(); i++) begin
      nextCycle();
      checkOutput("wave_btn", btn_n, wave_q[i]);
      checkOutput("wave_busy", busy, 1);
      checkOutput("wave_done", done, 0);
      checkOutput("wave_sent", presses_sent, sent_q[i]);
      if (i == abort_idx) begin
        applyStimulus(1'b0, '0, 1'b1);
        nextCycle();
        checkOutput("abort_btn", btn_n, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_sent", presses_sent, sent_q[i]);
        applyStimulus(1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
          nextCycle();
          checkOutput("post_abort_done", done, 0);
          checkOutput("post_abort_btn", btn_n, 1);
        end
        return;
      end else if (abort_idx >= 0 && i == P + 1) begin
        applyStimulus(1'b1, CNT_W'(7), 1'b0);
      end else if (rand_start && $urandom_range(0, 5) == 0) begin
        applyStimulus(1'b1, CNT_W'($urandom_range(1, 15)), 1'b0);
      end else begin
        applyStimulus(1'b0, '0, 1'b0);
      end
    end
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("end_done", done, 1);
    checkOutput("end_busy", busy, 0);
    checkOutput("end_btn", btn_n, 1);
    checkOutput("end_sent", presses_sent, n);
    nextCycle();
    checkOutput("end_done_pulse", done, 0);
  endtask

  initial begin
    rst      = 1'b1;
    lb_clear = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    nextCycle();
    checkOutput("reset_btn", btn_n, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sent", presses_sent, 0);
    nextCycle();
    rst      = 1'b0;
    lb_clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      checkOutput("idle_btn", btn_n, 1);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
      checkOutput("idle_sent", presses_sent, 0);
    end

    runBurst(1, -1, 1'b0);

    lb_clear = 1'b1;
    nextCycle();
    lb_clear = 1'b0;
    runBurst(3, -1, 1'b0);
    checkOutput("loopback_count", lb_count, 3);

    nextCycle();
    applyStimulus(1'b1, '0, 1'b0);
    nextCycle();
    checkOutput("zero_early_done", done, 0);
    applyStimulus(1'b0, '0, 1'b0);
    nextCycle();
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    checkOutput("zero_btn", btn_n, 1);
    nextCycle();
    checkOutput("zero_done_pulse", done, 0);
    checkOutput("zero_busy2", busy, 0);

    applyStimulus(1'b1, CNT_W'(5), 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("abort_start_busy", busy, 0);
      checkOutput("abort_start_btn", btn_n, 1);
      checkOutput("abort_start_done", done, 0);
    end

    runBurst(3, P + BE * BC + 2, 1'b0);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 3)) nextCycle();
      runBurst($urandom_range(1, 4), -1, 1'b1);
    end

    nextCycle();
    applyStimulus(1'b1, CNT_W'(2), 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0);
    nextCycle();
    checkOutput("pre_rst_btn", btn_n, 0);
    checkOutput("pre_rst_busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_btn", btn_n, 1);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_sent", presses_sent, 0);
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("post_rst_btn", btn_n, 1);
      checkOutput("post_rst_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
